// File: rtl/launch_pkg.sv
// launch_pkg: types and widths shared by the kernel launcher, its FIFO
// and its interface.
//   launcher_state_t : IDLE, LOAD, RUN, REPORT
//   launch_desc_t    : queued launch descriptor {kernel_id, thread_count}
package launch_pkg;

    localparam int unsigned THREAD_COUNT_WIDTH = 8;
    localparam int unsigned CYCLE_WIDTH        = 16;
    // Kernel tag width stored in a descriptor; the launcher's KID_WIDTH must match.
    localparam int unsigned DESC_KID_WIDTH     = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        REPORT
    } launcher_state_t;

    typedef struct packed {
        logic [DESC_KID_WIDTH-1:0]     kernel_id;
        logic [THREAD_COUNT_WIDTH-1:0] thread_count;
    } launch_desc_t;

endpackage

// File: rtl/kernel_launcher_if.sv
// kernel_launcher_if: host launch port, dispatcher control and completion port.
//   launch_* : valid/ready descriptor input from the host
//   disp_*   : reset/start/thread_count to the block dispatcher, done back
//   cmpl_*   : valid/ready completion record to the host
// Modports: slave = the launcher, master = the host/dispatcher side.
interface kernel_launcher_if #(
    parameter int unsigned KID_WIDTH = 4
);
    logic                                       launch_valid;
    logic                                       launch_ready;
    logic [launch_pkg::THREAD_COUNT_WIDTH-1:0]  launch_thread_count;
    logic [KID_WIDTH-1:0]                       launch_kernel_id;

    logic                                       disp_reset;
    logic                                       disp_start;
    logic [launch_pkg::THREAD_COUNT_WIDTH-1:0]  disp_thread_count;
    logic                                       disp_done;

    logic                                       cmpl_valid;
    logic                                       cmpl_ready;
    logic [KID_WIDTH-1:0]                       cmpl_kernel_id;
    logic [launch_pkg::CYCLE_WIDTH-1:0]         cmpl_cycles;

    modport slave (
        input  launch_valid, launch_thread_count, launch_kernel_id,
        output launch_ready,
        output disp_reset, disp_start, disp_thread_count,
        input  disp_done,
        output cmpl_valid, cmpl_kernel_id, cmpl_cycles,
        input  cmpl_ready
    );

    modport master (
        output launch_valid, launch_thread_count, launch_kernel_id,
        input  launch_ready,
        input  disp_reset, disp_start, disp_thread_count,
        output disp_done,
        input  cmpl_valid, cmpl_kernel_id, cmpl_cycles,
        output cmpl_ready
    );

endinterface

// File: rtl/launch_fifo.sv
// launch_fifo: synchronous FIFO of launch descriptors.
//   clk, rst_n      : clock, async active-low reset (empties the FIFO)
//   push_i, wdata_i : write request/data (ignored when full)
//   pop_i, rdata_c  : read request (ignored when empty) / head entry
//   full_c, empty_c : occupancy flags decoded from the level register
//   level_o         : occupancy, 0..DEPTH
module launch_fifo
    import launch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  launch_desc_t           wdata_i,
    input  logic                   pop_i,
    output launch_desc_t           rdata_c,
    output logic                   full_c,
    output logic                   empty_c,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    launch_desc_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_i && !full_c;
    assign pop_ok  = pop_i && !empty_c;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_c = mem_q[rd_ptr_q];
    assign full_c  = (level_q == LVL_W'(DEPTH));
    assign empty_c = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/kernel_launcher.sv
// kernel_launcher: queues kernel launch descriptors and runs them one at a
// time on the block dispatcher, returning one completion record per kernel.
//   clk, reset_n : clock, async active-low reset (discards queued/in-flight work)
//   bus          : kernel_launcher_if.slave (launch, dispatcher, completion ports)
//   busy         : FSM not idle or descriptors queued
//   queue_level  : FIFO occupancy
// Build option KERNEL_LAUNCHER_PERF_EN: when defined, a 16-bit saturating
// RUN-cycle counter drives cmpl_cycles; otherwise cmpl_cycles is tied to 0.
module kernel_launcher
    import launch_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned KID_WIDTH   = DESC_KID_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    kernel_launcher_if.slave             bus,
    output logic                         busy,
    output logic [$clog2(QUEUE_DEPTH):0] queue_level
);
    launcher_state_t                 state_q, state_d;
    launch_desc_t                    push_desc;
    launch_desc_t                    head_desc;
    logic                            fifo_full;
    logic                            fifo_empty;
    logic                            push;
    logic                            pop;
    logic [THREAD_COUNT_WIDTH-1:0]   cur_tc_q, cur_tc_d;
    logic [KID_WIDTH-1:0]            cur_kid_q, cur_kid_d;
    logic                            disp_reset_q;
    logic                            disp_start_q;
    logic                            cmpl_valid_q;

    // No bypass: a full FIFO refuses a push even while LOAD pops.
    assign push      = bus.launch_valid && !fifo_full;
    assign push_desc = '{kernel_id:    DESC_KID_WIDTH'(bus.launch_kernel_id),
                         thread_count: bus.launch_thread_count};

    launch_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (push),
        .wdata_i (push_desc),
        .pop_i   (pop),
        .rdata_c (head_desc),
        .full_c  (fifo_full),
        .empty_c (fifo_empty),
        .level_o (queue_level)
    );

    // Next-state and current-kernel latch.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        cur_tc_d  = cur_tc_q;
        cur_kid_d = cur_kid_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = LOAD;
            end
            LOAD: begin
                pop       = 1'b1;
                cur_tc_d  = head_desc.thread_count;
                cur_kid_d = KID_WIDTH'(head_desc.kernel_id);
                // A zero-thread kernel never starts the dispatcher.
                state_d   = (head_desc.thread_count == '0) ? REPORT : RUN;
            end
            RUN: begin
                if (bus.disp_done) state_d = REPORT;
            end
            REPORT: begin
                if (bus.cmpl_ready) state_d = fifo_empty ? IDLE : LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, current kernel and registered per-state outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cur_tc_q     <= '0;
            cur_kid_q    <= '0;
            disp_reset_q <= 1'b1;
            disp_start_q <= 1'b0;
            cmpl_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_tc_q     <= cur_tc_d;
            cur_kid_q    <= cur_kid_d;
            disp_reset_q <= (state_d != RUN);
            disp_start_q <= (state_d == RUN);
            cmpl_valid_q <= (state_d == REPORT);
        end
    end

`ifdef KERNEL_LAUNCHER_PERF_EN
    logic [CYCLE_WIDTH-1:0] cycles_q, cycles_d;

    // Counts every RUN cycle including the one that sees disp_done; saturates.
    always_comb begin
        cycles_d = cycles_q;
        if (state_q == LOAD) begin
            cycles_d = '0;
        end else if (state_q == RUN && cycles_q != '1) begin
            cycles_d = cycles_q + CYCLE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cycles_q <= '0;
        else          cycles_q <= cycles_d;
    end

    assign bus.cmpl_cycles = cycles_q;
`else
    assign bus.cmpl_cycles = '0;
`endif

    assign bus.launch_ready      = !fifo_full;
    assign bus.disp_reset        = disp_reset_q;
    assign bus.disp_start        = disp_start_q;
    assign bus.disp_thread_count = cur_tc_q;
    assign bus.cmpl_valid        = cmpl_valid_q;
    assign bus.cmpl_kernel_id    = cur_kid_q;
    assign busy                  = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_kernel_launcher.sv
// tb_kernel_launcher: directed self-checking bench for kernel_launcher.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_kernel_launcher;
    localparam int unsigned KID_W = 4;
`ifdef KERNEL_LAUNCHER_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       busy;
    logic [2:0] queue_level;

    int n_checks = 0;
    int n_fail   = 0;
    int k;
    int exp_ids [5] = '{9, 10, 11, 12, 13};

    kernel_launcher_if #(.KID_WIDTH(KID_W)) bus ();

    kernel_launcher #(
        .QUEUE_DEPTH (4),
        .KID_WIDTH   (KID_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .busy        (busy),
        .queue_level (queue_level)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_launch(input logic v, input int tc, input int id);
        bus.launch_valid        = v;
        bus.launch_thread_count = 8'(tc);
        bus.launch_kernel_id    = KID_W'(id);
    endtask

    function automatic logic [31:0] exp_cyc(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n        = 1'b0;
        drive_launch(1'b0, 0, 0);
        bus.disp_done  = 1'b0;
        bus.cmpl_ready = 1'b0;

        // Reset state
        #12;
        check_eq("rst_disp_reset", bus.disp_reset, 1);
        check_eq("rst_disp_start", bus.disp_start, 0);
        check_eq("rst_disp_tc", bus.disp_thread_count, 0);
        check_eq("rst_cmpl_valid", bus.cmpl_valid, 0);
        check_eq("rst_cmpl_id", bus.cmpl_kernel_id, 0);
        check_eq("rst_cmpl_cycles", bus.cmpl_cycles, 0);
        check_eq("rst_ready", bus.launch_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_level", queue_level, 0);
        #10 reset_n = 1'b1;
        step();

        // Single kernel: tc=40, id=3, done seen 11 RUN cycles in
        drive_launch(1'b1, 40, 3);
        step();
        drive_launch(1'b0, 0, 0);
        check_eq("t1_level_acc", queue_level, 1);
        check_eq("t1_busy", busy, 1);
        check_eq("t1_start_idle", bus.disp_start, 0);
        step();
        check_eq("t1_start_load", bus.disp_start, 0);
        check_eq("t1_reset_load", bus.disp_reset, 1);
        step();
        check_eq("t1_start_run", bus.disp_start, 1);
        check_eq("t1_reset_run", bus.disp_reset, 0);
        check_eq("t1_tc", bus.disp_thread_count, 40);
        check_eq("t1_level_run", queue_level, 0);
        repeat (10) step();
        check_eq("t1_start_hold", bus.disp_start, 1);
        check_eq("t1_cmpl_early", bus.cmpl_valid, 0);
        bus.disp_done = 1'b1;
        step();
        bus.disp_done = 1'b0;
        check_eq("t1_cmpl_valid", bus.cmpl_valid, 1);
        check_eq("t1_cmpl_id", bus.cmpl_kernel_id, 3);
        check_eq("t1_cmpl_cycles", bus.cmpl_cycles, exp_cyc(11));
        check_eq("t1_start_rep", bus.disp_start, 0);
        check_eq("t1_reset_rep", bus.disp_reset, 1);
        bus.cmpl_ready = 1'b1;
        step();
        bus.cmpl_ready = 1'b0;
        check_eq("t1_cmpl_done", bus.cmpl_valid, 0);
        check_eq("t1_busy_end", busy, 0);

        // Zero threads: tc=0, id=7
        drive_launch(1'b1, 0, 7);
        step();
        drive_launch(1'b0, 0, 0);
        step();
        check_eq("t3_start_load", bus.disp_start, 0);
        step();
        check_eq("t3_start_rep", bus.disp_start, 0);
        check_eq("t3_cmpl_valid", bus.cmpl_valid, 1);
        check_eq("t3_cmpl_id", bus.cmpl_kernel_id, 7);
        check_eq("t3_cmpl_cycles", bus.cmpl_cycles, 0);
        bus.cmpl_ready = 1'b1;
        step();
        bus.cmpl_ready = 1'b0;
        check_eq("t3_busy_end", busy, 0);

        // Push during LOAD at level 2, done high on RUN entry, backpressure
        drive_launch(1'b1, 5, 1);
        step();
        drive_launch(1'b1, 6, 2);
        step();
        check_eq("t4_level_load", queue_level, 2);
        drive_launch(1'b1, 0, 5);
        bus.disp_done = 1'b1;
        step();
        drive_launch(1'b0, 0, 0);
        check_eq("t4_level_pushpop", queue_level, 2);
        check_eq("t4_start_a", bus.disp_start, 1);
        check_eq("t4_tc_a", bus.disp_thread_count, 5);
        step();
        bus.disp_done = 1'b0;
        check_eq("t4_cmpl_id_a", bus.cmpl_kernel_id, 1);
        check_eq("t4_cmpl_cyc_a", bus.cmpl_cycles, exp_cyc(1));
        for (int c = 0; c < 20; c++) begin
            check_eq("t4_bp_valid", bus.cmpl_valid, 1);
            check_eq("t4_bp_id", bus.cmpl_kernel_id, 1);
            check_eq("t4_bp_cycles", bus.cmpl_cycles, exp_cyc(1));
            check_eq("t4_bp_reset", bus.disp_reset, 1);
            check_eq("t4_bp_start", bus.disp_start, 0);
            check_eq("t4_bp_level", queue_level, 2);
            step();
        end
        bus.cmpl_ready = 1'b1;
        step();
        bus.cmpl_ready = 1'b0;
        check_eq("t4_load_valid", bus.cmpl_valid, 0);
        check_eq("t4_load_start", bus.disp_start, 0);
        check_eq("t4_load_reset", bus.disp_reset, 1);
        step();
        check_eq("t4_start_b", bus.disp_start, 1);
        check_eq("t4_tc_b", bus.disp_thread_count, 6);
        check_eq("t4_level_b", queue_level, 1);
        bus.disp_done = 1'b1;
        step();
        bus.disp_done = 1'b0;
        check_eq("t4_cmpl_id_b", bus.cmpl_kernel_id, 2);
        check_eq("t4_cmpl_cyc_b", bus.cmpl_cycles, exp_cyc(1));
        bus.cmpl_ready = 1'b1;
        step();
        bus.cmpl_ready = 1'b0;
        step();
        check_eq("t4_start_c", bus.disp_start, 0);
        check_eq("t4_cmpl_valid_c", bus.cmpl_valid, 1);
        check_eq("t4_cmpl_id_c", bus.cmpl_kernel_id, 5);
        check_eq("t4_cmpl_cyc_c", bus.cmpl_cycles, 0);
        bus.cmpl_ready = 1'b1;
        step();
        bus.cmpl_ready = 1'b0;
        check_eq("t4_busy_end", busy, 0);

        // Fill: one kernel stuck in RUN, four queued, fifth held off
        drive_launch(1'b1, 1, 8);
        step();
        drive_launch(1'b0, 0, 0);
        step();
        step();
        check_eq("t2_run", bus.disp_start, 1);
        for (int i = 0; i < 4; i++) begin
            check_eq("t2_ready_fill", bus.launch_ready, 1);
            drive_launch(1'b1, 1, 9 + i);
            step();
        end
        check_eq("t2_full_ready", bus.launch_ready, 0);
        check_eq("t2_full_level", queue_level, 4);
        drive_launch(1'b1, 1, 13);
        step();
        check_eq("t2_held_level", queue_level, 4);
        bus.disp_done = 1'b1;
        step();
        check_eq("t2_cmpl_id0", bus.cmpl_kernel_id, 8);
        check_eq("t2_rep_level", queue_level, 4);
        bus.cmpl_ready = 1'b1;
        step();
        bus.cmpl_ready = 1'b0;
        check_eq("t2_load_level", queue_level, 4);
        check_eq("t2_load_ready", bus.launch_ready, 0);
        step();
        check_eq("t2_nobypass_level", queue_level, 3);
        check_eq("t2_pop_ready", bus.launch_ready, 1);
        check_eq("t2_run2", bus.disp_start, 1);
        step();
        drive_launch(1'b0, 0, 0);
        check_eq("t2_refill_level", queue_level, 4);
        bus.cmpl_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 60 && k < 5; c++) begin
            if (bus.cmpl_valid) begin
                check_eq($sformatf("t2_drain_id%0d", k), bus.cmpl_kernel_id, exp_ids[k]);
                k++;
            end
            step();
        end
        check_eq("t2_drain_count", k, 5);
        bus.cmpl_ready = 1'b0;
        bus.disp_done  = 1'b0;
        step();
        check_eq("t2_busy_end", busy, 0);

        // Async reset mid-RUN with one kernel still queued
        drive_launch(1'b1, 9, 4);
        step();
        drive_launch(1'b1, 9, 6);
        step();
        drive_launch(1'b0, 0, 0);
        step();
        check_eq("t5_run", bus.disp_start, 1);
        check_eq("t5_level", queue_level, 1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t5_rst_start", bus.disp_start, 0);
        check_eq("t5_rst_reset", bus.disp_reset, 1);
        check_eq("t5_rst_valid", bus.cmpl_valid, 0);
        check_eq("t5_rst_level", queue_level, 0);
        check_eq("t5_rst_busy", busy, 0);
        #2 reset_n = 1'b1;
        bus.disp_done = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check_eq("t5_no_stale", bus.cmpl_valid, 0);
        end
        check_eq("t5_busy_end", busy, 0);
        bus.disp_done = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
